neuron_mac_sequencer: RTL and testbench
=======================================

Name: neuron_mac_sequencer

Overview:
- Upstream feeder for the fixed-point `accumulator` inside one NAR-Net neuron.
- Accepts a start command, then sequences one dot product of NUM_INPUTS terms:
  - clears the accumulator;
  - injects the bias;
  - streams x*w products, each scaled and saturated to Q-format.
- Captures the accumulator's output as the neuron pre-activation result and pulses result_valid.

Parameters:
- N, 10, data word width (signed, two's complement).
- Q, 9, fractional bits of every x, w, bias and product.
- NUM_INPUTS, 4, number of x/w pairs per dot product (>=1).
- CNT_W, 8, input counter width; must satisfy 2**CNT_W > NUM_INPUTS.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  begin a dot product; sampled only in IDLE.
- bias  in  N  signed bias; sampled on the start-accept edge.
- in_valid  in  1  x/w pair valid.
- in_ready  out  1  sequencer accepts a pair this cycle.
- x  in  N  signed activation input.
- w  in  N  signed weight input.
- acc_rst  out  1  to accumulator rst (synchronous clear).
- acc_add  out  1  to accumulator add.
- acc_a  out  N  to accumulator a.
- acc_out  in  N  from accumulator out.
- result  out  N  captured dot-product result.
- result_valid  out  1  one-cycle pulse, result is new.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (rst=0, async) forces:
  - state=IDLE, prod_vld=0, count=0;
  - result=0, result_valid=0, in_ready=0, acc_rst=0, acc_add=0, acc_a=0.
  - Accumulator content left stale; CLEAR always precedes use.
- States and transitions:
  - IDLE: start=1 -> CLEAR; latch bias.
  - CLEAR (1 cycle): acc_rst=1 -> BIAS.
  - BIAS (1 cycle): acc_add=1, acc_a=bias_reg -> MAC; count=0.
  - MAC:
    - in_ready=1.
    - Handshake (in_valid&in_ready): register prod_reg=fx(x,w), prod_vld=1; otherwise prod_vld=0.
    - count increments per handshake.
    - Handshake with count==NUM_INPUTS-1 -> DRAIN.
  - DRAIN (1 cycle): in_ready=0; the last product is added -> CAPTURE.
  - CAPTURE (1 cycle): result<=acc_out, result_valid<=1 (high the following cycle) -> IDLE.
- Accumulator drive outputs:
  - acc_add = (state==BIAS) | prod_vld.
  - acc_a = (state==BIAS) ? bias_reg : prod_reg.
  - Both derived from registers only; no combinational path from x/w/in_valid.
- fx(x,w) arithmetic:
  - p = x*w, full 2N-bit signed.
  - s = p >>> Q (arithmetic shift, truncation toward -inf).
  - Saturate s to [-2**(N-1), 2**(N-1)-1].
- Latency with in_valid held high:
  - start-accept edge = edge 0; CLEAR = cycle 1; BIAS = cycle 2.
  - MAC = cycles 3..2+NUM_INPUTS; DRAIN = 3+NUM_INPUTS; CAPTURE = 4+NUM_INPUTS.
  - result_valid high in cycle 5+NUM_INPUTS.
  - in_valid gaps stretch MAC only; a gap cycle produces no add.
- Boundary conditions:
  - start while busy: ignored, no queuing.
  - start in the IDLE cycle immediately after CAPTURE: accepted; result_valid pulse still emitted.
  - bias and x/w changes outside their sampling points: no effect.
  - Reset mid-operation: immediate return to IDLE; no result_valid; the next start runs a full clean sequence.
  - NUM_INPUTS=1: MAC lasts exactly one handshake.
- result holds its value until the next CAPTURE.

Decomposition:
- Shared package nn_pkg:
  - state enum (IDLE, CLEAR, BIAS, MAC, DRAIN, CAPTURE);
  - saturation limit constants derived from N: SAT_MAX, SAT_MIN.
- Sub-module fx_mul_sat: combinational signed multiply, >>>Q, saturate. Reused by later neuron stages.

Test Plan:
- Continuous stream, NUM_INPUTS=4, bias=10, pairs (256,256),(128,256),(-256,256),(256,256) -> acc_a sequence 10,128,64,-128,128; result=202; result_valid exactly in cycle 9 after start edge.
- Product saturation: x=-512, w=-512 -> acc_a=511 (not 512); x=-512, w=511 -> s=-511, no clip.
- Truncation: x=-1, w=1 -> acc_a=-1; x=1, w=1 -> acc_a=0.
- Backpressure: same data as test 1 with in_valid low for 2 cycles between each pair -> result=202, exactly 5 acc_add pulses, result_valid 6 cycles later than test 1.
- Start pulsed during MAC -> ignored, single result_valid; back-to-back start right after CAPTURE -> second result correct.
- rst low for 1 cycle during MAC (after 2 pairs) -> busy=0, in_ready=0, no result_valid; restart with test 1 data -> result=202.

Source files
------------

// File: rtl/nn_pkg.sv
// rtl/nn_pkg.sv - shared neuron types, sequencer states and saturation limits
package nn_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    BIAS,
    MAC,
    DRAIN,
    CAPTURE
  } state_t;

  localparam int N_DEFAULT = 10;

  function automatic int sat_max(input int n);
    return (1 << (n - 1)) - 1;
  endfunction

  function automatic int sat_min(input int n);
    return -(1 << (n - 1));
  endfunction

  localparam int SAT_MAX = sat_max(N_DEFAULT);
  localparam int SAT_MIN = sat_min(N_DEFAULT);

endpackage

// File: rtl/fx_mul_sat.sv
// rtl/fx_mul_sat.sv - combinational Q-format signed multiply, arithmetic shift, saturate
module fx_mul_sat
  import nn_pkg::*;
#(
  parameter int N = 10,
  parameter int Q = 9
) (
  input  logic signed [N-1:0] a,
  input  logic signed [N-1:0] b,
  output logic signed [N-1:0] y
);

  localparam int PW = 2 * N;
  localparam logic signed [PW-1:0] HI = PW'(sat_max(N));
  localparam logic signed [PW-1:0] LO = PW'(sat_min(N));

  logic signed [PW-1:0] p;
  logic signed [PW-1:0] s;

  always_comb begin
    p = a * b;
    // arithmetic shift rounds toward -inf, so small negative products become -1
    s = p >>> Q;
    if (s > HI) begin
      y = HI[N-1:0];
    end else if (s < LO) begin
      y = LO[N-1:0];
    end else begin
      y = s[N-1:0];
    end
  end

endmodule

// File: rtl/neuron_mac_sequencer.sv
// rtl/neuron_mac_sequencer.sv - sequences clear, bias and x*w products into one neuron accumulator
module neuron_mac_sequencer
  import nn_pkg::*;
#(
  parameter int N          = 10,
  parameter int Q          = 9,
  parameter int NUM_INPUTS = 4,
  parameter int CNT_W      = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic signed [N-1:0] bias,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [N-1:0] x,
  input  logic signed [N-1:0] w,
  output logic                acc_rst,
  output logic                acc_add,
  output logic signed [N-1:0] acc_a,
  input  logic signed [N-1:0] acc_out,
  output logic signed [N-1:0] result,
  output logic                result_valid,
  output logic                busy
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_INPUTS - 1);

  state_t              state;
  state_t              state_n;
  logic signed [N-1:0] bias_reg;
  logic signed [N-1:0] prod_reg;
  logic signed [N-1:0] prod;
  logic                prod_vld;
  logic [CNT_W-1:0]    count;
  logic                hs;

  fx_mul_sat #(.N(N), .Q(Q)) u_mul (
    .a (x),
    .b (w),
    .y (prod)
  );

  assign in_ready = (state == MAC);
  assign hs       = in_valid & in_ready;
  assign acc_rst  = (state == CLEAR);
  assign busy     = (state != IDLE);
  // accumulator drive comes only from registers, never straight from x/w/in_valid
  assign acc_add  = (state == BIAS) | prod_vld;
  assign acc_a    = (state == BIAS) ? bias_reg : prod_reg;

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = CLEAR;
      CLEAR:   state_n = BIAS;
      BIAS:    state_n = MAC;
      MAC:     if (hs && (count == LAST_IDX)) state_n = DRAIN;
      DRAIN:   state_n = CAPTURE;
      CAPTURE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      bias_reg     <= '0;
      prod_reg     <= '0;
      prod_vld     <= 1'b0;
      count        <= '0;
      result       <= '0;
      result_valid <= 1'b0;
    end else begin
      state        <= state_n;
      prod_vld     <= hs;
      result_valid <= 1'b0;
      if (hs) prod_reg <= prod;
      case (state)
        IDLE:    if (start) bias_reg <= bias;
        BIAS:    count <= '0;
        MAC:     if (hs) count <= count + 1'b1;
        CAPTURE: begin
          result       <= acc_out;
          result_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_mac_sequencer.sv
// tb/tb_neuron_mac_sequencer.sv - directed self-checking bench with accumulator and dot-product model
module tb_neuron_mac_sequencer;

  localparam int N  = 10;
  localparam int Q  = 9;
  localparam int NI = 4;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                start = 1'b0;
  logic                in_valid = 1'b0;
  logic signed [N-1:0] bias = '0;
  logic signed [N-1:0] x = '0;
  logic signed [N-1:0] w = '0;
  logic signed [N-1:0] acc_out;
  logic signed [N-1:0] acc_a;
  logic signed [N-1:0] result;
  logic                in_ready, acc_rst, acc_add, result_valid, busy;

  neuron_mac_sequencer #(.N(N), .Q(Q), .NUM_INPUTS(NI), .CNT_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .bias         (bias),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .x            (x),
    .w            (w),
    .acc_rst      (acc_rst),
    .acc_add      (acc_add),
    .acc_a        (acc_a),
    .acc_out      (acc_out),
    .result       (result),
    .result_valid (result_valid),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  function automatic int sat(input int v);
    if (v > 511) return 511;
    if (v < -512) return -512;
    return v;
  endfunction

  function automatic int fx(input int a, input int b);
    int p;
    p = a * b;
    return sat(p >>> Q);
  endfunction

  // external saturating accumulator the sequencer feeds
  logic signed [N-1:0] acc_q = '0;
  assign acc_out = acc_q;
  always @(posedge clk) begin
    if (acc_rst) acc_q <= '0;
    else if (acc_add) acc_q <= N'(sat(int'(acc_q) + int'(acc_a)));
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  int exp_a[$];
  int exp_res[$];
  int log_a[$];
  int add_count = 0;
  int clr_count = 0;
  int rv_count = 0;
  int last_rv_cycle = 0;
  int held_res = 0;

  always @(negedge rst) held_res = 0;

  always @(negedge clk) begin
    if (rst) begin
      if (acc_add) begin
        add_count++;
        log_a.push_back(int'(acc_a));
        if (exp_a.size() == 0) chk("unexpected_add", int'(acc_a), 9999);
        else chk("acc_a", int'(acc_a), exp_a.pop_front());
      end
      if (acc_rst) clr_count++;
      if (acc_rst && acc_add) chk("clear_and_add_same_cycle", 1, 0);
      if (in_ready && !busy) chk("in_ready_without_busy", 1, 0);
      if (result_valid) begin
        rv_count++;
        last_rv_cycle = cycle;
        if (exp_res.size() == 0) chk("unexpected_result_valid", int'(result), 9999);
        else begin
          held_res = exp_res.pop_front();
          chk("result", int'(result), held_res);
        end
      end else begin
        chk("result_hold", int'(result), held_res);
      end
    end
  end

  int t1x[NI] = '{256, 128, -256, 256};
  int t1w[NI] = '{256, 256, 256, 256};
  int sx[NI]  = '{-512, -512, -1, 1};
  int sw[NI]  = '{-512, 511, 1, 1};
  int bx[NI]  = '{100, 300, -300, 7};
  int bw[NI]  = '{200, 400, 100, -9};

  task automatic feed(input int xs[NI], input int ws[NI], input int cnt, input int gap,
                      input bit poke);
    int t;
    for (int i = 0; i < cnt; i++) begin
      if (i > 0) begin
        repeat (gap) begin
          in_valid = 1'b0;
          x = N'($urandom);
          w = N'($urandom);
          @(negedge clk);
        end
      end
      in_valid = 1'b1;
      x = N'(xs[i]);
      w = N'(ws[i]);
      if (poke && i == 1) start = 1'b1;
      t = 0;
      while (!in_ready && t < 50) begin
        @(negedge clk);
        t++;
      end
      if (t >= 50) chk("in_ready_timeout", 0, 1);
      @(negedge clk);
      start = 1'b0;
    end
    in_valid = 1'b0;
    x = N'($urandom);
    w = N'($urandom);
  endtask

  task automatic begin_op(input int b, output int c0);
    int t;
    t = 0;
    while (busy && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) chk("idle_timeout", 0, 1);
    start = 1'b1;
    bias = N'(b);
    @(negedge clk);
    start = 1'b0;
    bias = N'($urandom);
    c0 = cycle - 1;
  endtask

  task automatic run_op(input int b, input int xs[NI], input int ws[NI], input int gap,
                        input bit poke, output int c0);
    int acc;
    acc = b;
    exp_a.push_back(b);
    for (int i = 0; i < NI; i++) begin
      exp_a.push_back(fx(xs[i], ws[i]));
      acc = sat(acc + fx(xs[i], ws[i]));
    end
    exp_res.push_back(acc);
    begin_op(b, c0);
    feed(xs, ws, NI, gap, poke);
  endtask

  task automatic wait_rv(input int target);
    int t;
    t = 0;
    while (rv_count < target && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (rv_count < target) chk("result_valid_timeout", rv_count, target);
  endtask

  int c0, c1, base_log, base_add, base_rv, base_clr;

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_result", int'(result), 0);
    chk("reset_result_valid", int'(result_valid), 0);
    chk("reset_in_ready", int'(in_ready), 0);
    chk("reset_acc_rst", int'(acc_rst), 0);
    chk("reset_acc_add", int'(acc_add), 0);
    chk("reset_acc_a", int'(acc_a), 0);
    chk("reset_busy", int'(busy), 0);
    #2 rst = 1'b1;
    @(negedge clk);

    // continuous stream
    base_log = log_a.size(); base_add = add_count; base_rv = rv_count;
    run_op(10, t1x, t1w, 0, 1'b0, c0);
    wait_rv(base_rv + 1);
    chk("t1_latency", last_rv_cycle - c0, 9);
    chk("t1_result_literal", int'(result), 202);
    chk("t1_add_pulses", add_count - base_add, 5);
    chk("t1_a0", log_a[base_log + 0], 10);
    chk("t1_a1", log_a[base_log + 1], 128);
    chk("t1_a2", log_a[base_log + 2], 64);
    chk("t1_a3", log_a[base_log + 3], -128);
    chk("t1_a4", log_a[base_log + 4], 128);

    // saturation and truncation products
    base_log = log_a.size(); base_rv = rv_count;
    run_op(0, sx, sw, 0, 1'b0, c0);
    wait_rv(base_rv + 1);
    chk("sat_pos_clip", log_a[base_log + 1], 511);
    chk("sat_no_clip", log_a[base_log + 2], -511);
    chk("trunc_neg", log_a[base_log + 3], -1);
    chk("trunc_pos", log_a[base_log + 4], 0);
    chk("sat_result_literal", int'(result), -1);

    // backpressure: two idle cycles between pairs
    base_add = add_count; base_rv = rv_count;
    run_op(10, t1x, t1w, 2, 1'b0, c0);
    wait_rv(base_rv + 1);
    chk("bp_latency", last_rv_cycle - c0, 15);
    chk("bp_add_pulses", add_count - base_add, 5);
    chk("bp_result_literal", int'(result), 202);

    // start poked during MAC, then back-to-back start in the IDLE cycle after CAPTURE
    base_rv = rv_count;
    run_op(10, t1x, t1w, 0, 1'b1, c0);
    run_op(-5, bx, bw, 0, 1'b0, c1);
    chk("b2b_start_gap", c1 - c0, 9);
    wait_rv(base_rv + 2);
    chk("b2b_latency", last_rv_cycle - c1, 9);
    chk("b2b_result_literal", int'(result), 208);
    repeat (12) @(negedge clk);
    chk("no_queued_start", rv_count, base_rv + 2);
    chk("idle_after_b2b", int'(busy), 0);

    // reset after two pairs of a sequence
    base_rv = rv_count;
    exp_a.push_back(10);
    exp_a.push_back(fx(t1x[0], t1w[0]));
    exp_a.push_back(fx(t1x[1], t1w[1]));
    begin_op(10, c0);
    feed(t1x, t1w, 2, 0, 1'b0);
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_result_cleared", int'(result), 0);
    chk("rst_pending_adds", exp_a.size(), 0);
    repeat (15) @(negedge clk);
    chk("rst_no_result_valid", rv_count, base_rv);
    base_clr = clr_count; base_add = add_count;
    run_op(10, t1x, t1w, 0, 1'b0, c0);
    wait_rv(base_rv + 1);
    chk("restart_latency", last_rv_cycle - c0, 9);
    chk("restart_result_literal", int'(result), 202);
    chk("restart_clear_pulses", clr_count - base_clr, 1);
    chk("restart_add_pulses", add_count - base_add, 5);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
